// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings (buttons,
// collision detector, score counter, display).
interface game_ctrl_if #(
    parameter int SCORE_W = 32
);
    logic               start;
    logic               pause;
    logic               hit;
    logic [SCORE_W-1:0] score_in;
    logic [1:0]         state;
    logic               running;
    logic               score_clr;
    logic               score_tick;
    logic [SCORE_W-1:0] high_score;
    logic               new_record;

    modport master (
        input  start, pause, hit, score_in,
        output state, running, score_clr, score_tick, high_score, new_record
    );

    modport slave (
        output start, pause, hit, score_in,
        input  state, running, score_clr, score_tick, high_score, new_record
    );
endinterface

// File: rtl/game_ctrl.sv
// Goose-run game sequencer: idle/run/pause/over FSM, score clear/tick pulses,
// and the session high score with its new-record flag.
module game_ctrl #(
    parameter int TICK_DIV = 1_000_000,
    parameter int HOLD_CYC = 25_000_000,
    parameter int SCORE_W  = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    game_ctrl_if.master bus
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt, tick_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
    logic               running_q;
    logic               score_clr_q, score_clr_d;
    logic               score_tick_q, score_tick_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;
    logic               new_record_q, new_record_d;
    logic               restart_ok;

    assign restart_ok = (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tick_cnt     <= '0;
            hold_cnt     <= '0;
            running_q    <= 1'b0;
            score_clr_q  <= 1'b0;
            score_tick_q <= 1'b0;
            high_score_q <= '0;
            new_record_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt     <= tick_cnt_d;
            hold_cnt     <= hold_cnt_d;
            running_q    <= (state_d == RUN);
            score_clr_q  <= score_clr_d;
            score_tick_q <= score_tick_d;
            high_score_q <= high_score_d;
            new_record_q <= new_record_d;
        end
    end

    // A hit outranks a simultaneous pause; start outranks pause in IDLE/OVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.hit)        state_d = OVER;
                else if (bus.pause) state_d = PAUSE;
            end
            PAUSE:   if (bus.pause) state_d = RUN;
            OVER:    if (bus.start && restart_ok) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d   = tick_cnt;
        hold_cnt_d   = hold_cnt;
        score_clr_d  = 1'b0;
        score_tick_d = 1'b0;
        high_score_d = high_score_q;
        new_record_d = new_record_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    score_clr_d = 1'b1;
                    tick_cnt_d  = '0;
                end
            end
            RUN: begin
                // The score sampled on the hit cycle is final; a terminal-count tick is suppressed.
                if (bus.hit) begin
                    hold_cnt_d   = '0;
                    new_record_d = (bus.score_in > high_score_q);
                    if (bus.score_in > high_score_q) high_score_d = bus.score_in;
                end else if (!bus.pause) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        score_tick_d = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt + 1'b1;
                    end
                end
            end
            OVER: begin
                if (!restart_ok) hold_cnt_d = hold_cnt + 1'b1;
                if (bus.start && restart_ok) begin
                    score_clr_d  = 1'b1;
                    tick_cnt_d   = '0;
                    new_record_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.state      = state_q;
    assign bus.running    = running_q;
    assign bus.score_clr  = score_clr_q;
    assign bus.score_tick = score_tick_q;
    assign bus.high_score = high_score_q;
    assign bus.new_record = new_record_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a small behavioural score counter
// fed by score_clr/score_tick; inputs change and outputs are read on negedges.
module tb_game_ctrl;
    localparam int TICK_DIV = 4;
    localparam int HOLD_CYC = 8;
    localparam int SCORE_W  = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [SCORE_W-1:0] cnt;
    int                 total = 0;
    int                 bad   = 0;

    game_ctrl_if #(.SCORE_W(SCORE_W)) gif ();

    game_ctrl #(
        .TICK_DIV (TICK_DIV),
        .HOLD_CYC (HOLD_CYC),
        .SCORE_W  (SCORE_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (gif)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            cnt <= '0;
        else if (gif.score_clr)  cnt <= '0;
        else if (gif.score_tick) cnt <= cnt + 1'b1;
    end
    assign gif.score_in = cnt;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        reset_n   = 1'b0;
        gif.start = 1'b0;
        gif.pause = 1'b0;
        gif.hit   = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [13:0] outs;
        do_reset();
        reset_n = 1'b0;
        step(1);
        total++;
        if (gif.state !== 2'd0 || gif.high_score !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold: state=%0d high=%0d want 0/0", gif.state, gif.high_score);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            outs = {gif.state, gif.running, gif.score_clr, gif.score_tick, gif.high_score, gif.new_record};
            total++;
            if (outs !== 14'd0) begin
                bad++;
                $display("FAIL idle_outputs cycle %0d: got %h want 0000", i, outs);
            end
        end
        gif.pause = 1'b1;
        step(1);
        gif.pause = 1'b0;
        step(1);
        total++;
        if (gif.state !== 2'd0) begin
            bad++;
            $display("FAIL idle_pause: state=%0d want 0", gif.state);
        end
        gif.hit = 1'b1;
        step(3);
        total++;
        if (gif.state !== 2'd0 || gif.running !== 1'b0) begin
            bad++;
            $display("FAIL idle_hit: state=%0d running=%0d want 0/0", gif.state, gif.running);
        end
        gif.hit = 1'b0;
    endtask

    task automatic test_start_tick;
        do_reset();
        gif.start = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            step(1);
            gif.start = 1'b0;
            total++;
            if (gif.state !== 2'd1 || gif.running !== 1'b1) begin
                bad++;
                $display("FAIL run_state k=%0d: state=%0d running=%0d want 1/1", k, gif.state, gif.running);
            end
            total++;
            if (gif.score_clr !== (k == 1)) begin
                bad++;
                $display("FAIL clr_pulse k=%0d: got %0d want %0d", k, gif.score_clr, (k == 1));
            end
            total++;
            if (gif.score_tick !== (k > 1 && k % 4 == 1)) begin
                bad++;
                $display("FAIL tick_pulse k=%0d: got %0d want %0d", k, gif.score_tick, (k > 1 && k % 4 == 1));
            end
        end
        step(1);
        total++;
        if (cnt !== 8'd10) begin
            bad++;
            $display("FAIL tick_count: got %0d want 10", cnt);
        end
    endtask

    task automatic test_pause;
        do_reset();
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
        step(8);
        total++;
        if (gif.score_tick !== 1'b1 || cnt !== 8'd1) begin
            bad++;
            $display("FAIL pre_pause_tick: tick=%0d cnt=%0d want 1/1", gif.score_tick, cnt);
        end
        step(1);
        gif.pause = 1'b1;
        step(1);
        gif.pause = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step(1);
            total++;
            if (gif.state !== 2'd2 || gif.score_tick !== 1'b0 || gif.running !== 1'b0) begin
                bad++;
                $display("FAIL paused i=%0d: state=%0d tick=%0d running=%0d want 2/0/0",
                         i, gif.state, gif.score_tick, gif.running);
            end
        end
        gif.pause = 1'b1;
        step(1);
        gif.pause = 1'b0;
        total++;
        if (gif.state !== 2'd1) begin
            bad++;
            $display("FAIL resume_state: got %0d want 1", gif.state);
        end
        for (int k = 23; k <= 26; k++) begin
            if (k > 23) step(1);
            total++;
            if (gif.score_tick !== (k == 26)) begin
                bad++;
                $display("FAIL resume_tick k=%0d: got %0d want %0d", k, gif.score_tick, (k == 26));
            end
        end
        step(1);
        total++;
        if (cnt !== 8'd3) begin
            bad++;
            $display("FAIL resume_count: got %0d want 3", cnt);
        end
    endtask

    task automatic test_hit_record;
        do_reset();
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
        step(29);
        total++;
        if (cnt !== 8'd7) begin
            bad++;
            $display("FAIL game1_score: got %0d want 7", cnt);
        end
        gif.hit = 1'b1;
        step(1);
        gif.hit = 1'b0;
        total++;
        if (gif.state !== 2'd3 || gif.high_score !== 8'd7 || gif.new_record !== 1'b1 || gif.running !== 1'b0) begin
            bad++;
            $display("FAIL game1_over: state=%0d high=%0d rec=%0d run=%0d want 3/7/1/0",
                     gif.state, gif.high_score, gif.new_record, gif.running);
        end
        step(3);
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
        total++;
        if (gif.state !== 2'd3 || gif.score_clr !== 1'b0) begin
            bad++;
            $display("FAIL early_start: state=%0d clr=%0d want 3/0", gif.state, gif.score_clr);
        end
        step(5);
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
        total++;
        if (gif.state !== 2'd1 || gif.score_clr !== 1'b1 || gif.new_record !== 1'b0 || gif.high_score !== 8'd7) begin
            bad++;
            $display("FAIL restart1: state=%0d clr=%0d rec=%0d high=%0d want 1/1/0/7",
                     gif.state, gif.score_clr, gif.new_record, gif.high_score);
        end
        step(29);
        total++;
        if (cnt !== 8'd7) begin
            bad++;
            $display("FAIL game2_score: got %0d want 7", cnt);
        end
        gif.hit = 1'b1;
        step(1);
        gif.hit = 1'b0;
        total++;
        if (gif.state !== 2'd3 || gif.high_score !== 8'd7 || gif.new_record !== 1'b0) begin
            bad++;
            $display("FAIL game2_equal: state=%0d high=%0d rec=%0d want 3/7/0",
                     gif.state, gif.high_score, gif.new_record);
        end
        step(7);
        gif.start = 1'b1;
        step(1);
        total++;
        if (gif.state !== 2'd3) begin
            bad++;
            $display("FAIL hold_minus_one: state=%0d want 3", gif.state);
        end
        step(1);
        gif.start = 1'b0;
        total++;
        if (gif.state !== 2'd1 || gif.score_clr !== 1'b1) begin
            bad++;
            $display("FAIL hold_exact: state=%0d clr=%0d want 1/1", gif.state, gif.score_clr);
        end
        step(37);
        total++;
        if (cnt !== 8'd9) begin
            bad++;
            $display("FAIL game3_score: got %0d want 9", cnt);
        end
        gif.hit = 1'b1;
        step(1);
        gif.hit = 1'b0;
        total++;
        if (gif.state !== 2'd3 || gif.high_score !== 8'd9 || gif.new_record !== 1'b1) begin
            bad++;
            $display("FAIL game3_record: state=%0d high=%0d rec=%0d want 3/9/1",
                     gif.state, gif.high_score, gif.new_record);
        end
    endtask

    task automatic test_corners;
        // Start with pause in IDLE, then a hit landing on the terminal count.
        do_reset();
        gif.start = 1'b1;
        gif.pause = 1'b1;
        step(1);
        gif.start = 1'b0;
        gif.pause = 1'b0;
        total++;
        if (gif.state !== 2'd1 || gif.score_clr !== 1'b1) begin
            bad++;
            $display("FAIL start_pause: state=%0d clr=%0d want 1/1", gif.state, gif.score_clr);
        end
        step(1);
        total++;
        if (gif.state !== 2'd1) begin
            bad++;
            $display("FAIL pause_dropped: state=%0d want 1", gif.state);
        end
        step(6);
        gif.hit = 1'b1;
        step(1);
        gif.hit = 1'b0;
        total++;
        if (gif.state !== 2'd3 || gif.score_tick !== 1'b0 || gif.high_score !== 8'd1 || gif.new_record !== 1'b1) begin
            bad++;
            $display("FAIL hit_terminal: state=%0d tick=%0d high=%0d rec=%0d want 3/0/1/1",
                     gif.state, gif.score_tick, gif.high_score, gif.new_record);
        end
        step(1);
        total++;
        if (cnt !== 8'd1) begin
            bad++;
            $display("FAIL hit_terminal_cnt: got %0d want 1", cnt);
        end

        do_reset();
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
        step(2);
        gif.hit   = 1'b1;
        gif.pause = 1'b1;
        step(1);
        gif.hit   = 1'b0;
        gif.pause = 1'b0;
        total++;
        if (gif.state !== 2'd3 || gif.high_score !== 8'd0 || gif.new_record !== 1'b0) begin
            bad++;
            $display("FAIL hit_pause: state=%0d high=%0d rec=%0d want 3/0/0",
                     gif.state, gif.high_score, gif.new_record);
        end
    endtask

    task automatic test_reset_mid_run;
        do_reset();
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
        step(9);
        gif.hit = 1'b1;
        step(1);
        gif.hit = 1'b0;
        total++;
        if (gif.high_score !== 8'd2 || gif.new_record !== 1'b1) begin
            bad++;
            $display("FAIL mid_precond: high=%0d rec=%0d want 2/1", gif.high_score, gif.new_record);
        end
        step(8);
        gif.start = 1'b1;
        step(1);
        gif.start = 1'b0;
        total++;
        if (gif.state !== 2'd1) begin
            bad++;
            $display("FAIL mid_restart: state=%0d want 1", gif.state);
        end
        step(2);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (gif.state !== 2'd0 || gif.high_score !== 8'd0 || gif.running !== 1'b0 || gif.new_record !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: state=%0d high=%0d run=%0d rec=%0d want 0/0/0/0",
                     gif.state, gif.high_score, gif.running, gif.new_record);
        end
        step(1);
        reset_n = 1'b1;
        step(2);
        total++;
        if (gif.state !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_idle: state=%0d want 0", gif.state);
        end
    endtask

    initial begin
        test_reset();
        test_start_tick();
        test_pause();
        test_hit_record();
        test_corners();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Sequencing controller for the goose-run score datapath. Runs the game state machine (idle, running, paused, game over) and generates one-cycle control pulses for the score counter: clear at game start, increment at a fixed tick rate while running. It also keeps the session high score and a new-record flag for the display logic. It sits between the collision/button inputs and the score counter, and drives the counter only through `score_clr` and `score_tick`.

## Interface
- `TICK_DIV`, default 1_000_000: clock cycles per score point while running (≥2).
- `HOLD_CYC`, default 25_000_000: minimum cycles spent in OVER before `start` is accepted (≥1).
- `SCORE_W`, default 32: score width.
- `clk`  in  1  system clock; everything is rising-edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle synchronous pulse: start or restart a game.
- `pause`  in  1  one-cycle synchronous pulse: toggle RUN/PAUSE.
- `hit`  in  1  collision level, active-high.
- `score_in`  in  SCORE_W  current score from the score counter.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- `running`  out  1  high while `state`==RUN.
- `score_clr`  out  1  one-cycle pulse: clear the score counter.
- `score_tick`  out  1  one-cycle pulse: increment the score counter.
- `high_score`  out  SCORE_W  best score this session.
- `new_record`  out  1  the last game set a new high score.

## Operation
- All outputs are registered. Reset values: `state`=IDLE, and all other outputs 0. Internal `tick_cnt`=0, `hold_cnt`=0.
- IDLE: `start` → RUN, with `score_clr`=1 for one cycle and `tick_cnt`←0. `pause` and `hit` are ignored.
- RUN, evaluated in priority order:
  - `hit`=1 → OVER, `hold_cnt`←0, `high_score`←max(`high_score`, `score_in` sampled that cycle), `new_record`←(`score_in` > `high_score`).
  - Else `pause` → PAUSE, with `tick_cnt` frozen.
  - Else `tick_cnt` increments. At `TICK_DIV`-1 it wraps to 0 and `score_tick` pulses.
  - `start` is ignored.
- PAUSE: `pause` → RUN, and `tick_cnt` resumes from its frozen value. `hit` and `start` are ignored. No ticks are issued.
- OVER:
  - `hold_cnt` increments and saturates at `HOLD_CYC`.
  - `start` while `hold_cnt`==`HOLD_CYC` → RUN, with `score_clr` pulse, `tick_cnt`←0, `new_record`←0.
  - `start` before that is dropped, not queued.
  - `hit` and `pause` are ignored.
- Comparison is unsigned, and equality is not a record. `high_score` is cleared only by reset.
- Simultaneous events:
  - `hit` with a terminal count: no tick.
  - `hit` with `pause`: OVER.
  - `start` with `pause` in IDLE/OVER: start wins and `pause` is dropped.
- Reset mid-game returns immediately to IDLE and clears `high_score`.

## Timing
- A state change is visible one cycle after the qualifying input edge.
- `score_clr` is high in the first RUN cycle after `start`.
- `score_tick` is high in the cycle after the edge where `tick_cnt`==`TICK_DIV`-1 in RUN with `hit`=0. The first tick comes `TICK_DIV` cycles after entering RUN. Steady state is one tick every `TICK_DIV` cycles.
- `score_tick` and `score_clr` are never high in the same cycle.
- `high_score` and `new_record` update together with `state`=OVER. The counter's increment from the last tick before the hit counts only if it has already reached `score_in`.
- OVER lasts at least `HOLD_CYC`+1 cycles before a restart.

## Test plan
Bench parameters: `TICK_DIV`=4, `HOLD_CYC`=8, `SCORE_W`=8, with a behavioural counter driven by `score_clr`/`score_tick`.
- Reset then idle: after `reset_n` deasserts, all outputs are 0 for 20 cycles. Pulsing `pause` or holding `hit` leaves `state` at 0.
- Start and ticking: a `start` pulse gives `state`=1 and a `score_clr` pulse in the next cycle, followed by `score_tick` every 4 cycles. After 40 cycles the counter reads 10.
- Pause: `pause` after 2 ticks stops ticks for 12 cycles. A second `pause` resumes, and the next tick arrives after the remaining divider cycles, not a full 4.
- Hit and record: `hit` at score 7 gives `state`=3, `high_score`=7, `new_record`=1. In the next game, a hit at score 7 gives `new_record`=0 and `high_score` stays 7. A hit at score 9 gives `high_score`=9.
- Hold and restart: `start` 3 cycles into OVER is ignored. `start` after 9 cycles gives RUN, a `score_clr` pulse, and `new_record`=0.
- Corner cases:
  - `hit` on a terminal-count cycle gives no `score_tick`.
  - `hit` and `pause` together give OVER.
  - Dropping `reset_n` mid-RUN gives an immediate asynchronous return to IDLE with `high_score`=0.
